// File: rtl/sensor_adc_sampler.sv
// sensor_adc_sampler
//   Periodically reads both channels of an MCP3002-style 10-bit SPI ADC
//   (CH0 = soil moisture, CH1 = ambient light), holds the latest pair and
//   registers threshold flags for the irrigation controller.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        single-cycle request for an immediate conversion
//   i_m_thresh_1   moisture "dry" threshold
//   i_m_thresh_2   moisture "very dry" threshold
//   i_l_thresh     light "dark" threshold
//   i_adc_miso     ADC serial data out
//   o_adc_sclk     SPI clock, mode 0
//   o_adc_cs_n     ADC chip select, active low
//   o_adc_mosi     ADC command bit
//   o_moisture     last moisture code
//   o_light        last light code
//   o_m_dry        moisture < i_m_thresh_1
//   o_m_very_dry   moisture < i_m_thresh_2
//   o_l_dark       light < i_l_thresh
//   o_sample_valid one-cycle pulse when readings and flags update
//   o_busy         high from trigger acceptance until sample_valid

module sensor_adc_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [9:0] i_m_thresh_1,
    input  logic [9:0] i_m_thresh_2,
    input  logic [9:0] i_l_thresh,
    input  logic       i_adc_miso,
    output logic       o_adc_sclk,
    output logic       o_adc_cs_n,
    output logic       o_adc_mosi,
    output logic [9:0] o_moisture,
    output logic [9:0] o_light,
    output logic       o_m_dry,
    output logic       o_m_very_dry,
    output logic       o_l_dark,
    output logic       o_sample_valid,
    output logic       o_busy
);

    localparam int unsigned PerW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PerW-1:0] PerLast = PerW'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StGap,
        StUpdate
    } state_e;

    state_e            r_state;
    logic [7:0]        r_div_cnt;
    logic [3:0]        r_bit_cnt;    // SCLK period index; rising edge number is r_bit_cnt+1
    logic              r_ch;
    logic [9:0]        r_shift;
    logic [9:0]        r_ch0_data;
    logic [9:0]        r_ch1_data;
    logic [PerW-1:0]   r_period_cnt;
    logic              r_period_hit;
    logic              r_sclk;
    logic              r_cs_n;
    logic              r_mosi;
    logic [9:0]        r_moisture;
    logic [9:0]        r_light;
    logic              r_m_dry;
    logic              r_m_very_dry;
    logic              r_l_dark;
    logic              r_sample_valid;
    logic              r_busy;

    logic              w_trigger;
    logic              w_div_done;

    // Command word, MSB first: start, single-ended, channel, MSB-first; zeros after.
    function automatic logic cmd_bit(input logic [3:0] idx, input logic ch);
        case (idx)
            4'd0, 4'd1, 4'd3: cmd_bit = 1'b1;
            4'd2:             cmd_bit = ch;
            default:          cmd_bit = 1'b0;
        endcase
    endfunction

    assign w_trigger  = (r_state == StIdle) && (i_start || r_period_hit);
    assign w_div_done = (r_div_cnt == DivLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_div_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_ch           <= 1'b0;
            r_shift        <= '0;
            r_ch0_data     <= '0;
            r_ch1_data     <= '0;
            r_period_cnt   <= '0;
            r_period_hit   <= 1'b0;
            r_sclk         <= 1'b0;
            r_cs_n         <= 1'b1;
            r_mosi         <= 1'b0;
            r_moisture     <= '0;
            r_light        <= '0;
            r_m_dry        <= 1'b0;
            r_m_very_dry   <= 1'b0;
            r_l_dark       <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_trigger) begin
                        r_state      <= StCsSetup;
                        r_cs_n       <= 1'b0;
                        r_sclk       <= 1'b0;
                        r_mosi       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_div_cnt    <= '0;
                        r_bit_cnt    <= '0;
                        r_ch         <= 1'b0;
                        r_period_cnt <= '0;
                        r_period_hit <= 1'b0;
                    end else begin
                        if (r_period_cnt != PerLast) begin
                            r_period_cnt <= r_period_cnt + PerW'(1);
                        end
                        // Registered expiry: the trigger is taken the cycle after the
                        // counter sits at its terminal value.
                        r_period_hit <= (r_period_cnt == PerLast);
                    end
                end

                StCsSetup: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        r_state   <= StShift;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                StShift: begin
                    if (!w_div_done) begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end else begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            // Edges 6..15 carry D9..D0; null bit and edge 16 are skipped.
                            if ((r_bit_cnt >= 4'd5) && (r_bit_cnt <= 4'd14)) begin
                                r_shift <= {r_shift[8:0], i_adc_miso};
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit_cnt == 4'd15) begin
                                r_state <= StCsHold;
                                r_mosi  <= 1'b0;
                                if (r_ch) begin
                                    r_ch1_data <= r_shift;
                                end else begin
                                    r_ch0_data <= r_shift;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_mosi    <= cmd_bit(r_bit_cnt + 4'd1, r_ch);
                            end
                        end
                    end
                end

                StCsHold: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        r_cs_n    <= 1'b1;
                        r_state   <= StGap;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                StGap: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        if (!r_ch) begin
                            r_ch      <= 1'b1;
                            r_bit_cnt <= '0;
                            r_cs_n    <= 1'b0;
                            r_mosi    <= 1'b1;
                            r_state   <= StCsSetup;
                        end else begin
                            // Flags come from the shadows so they change with the readings.
                            r_moisture     <= r_ch0_data;
                            r_light        <= r_ch1_data;
                            r_m_dry        <= (r_ch0_data < i_m_thresh_1);
                            r_m_very_dry   <= (r_ch0_data < i_m_thresh_2);
                            r_l_dark       <= (r_ch1_data < i_l_thresh);
                            r_sample_valid <= 1'b1;
                            r_state        <= StUpdate;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                StUpdate: begin
                    r_busy  <= 1'b0;
                    r_ch    <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_adc_sclk     = r_sclk;
    assign o_adc_cs_n     = r_cs_n;
    assign o_adc_mosi     = r_mosi;
    assign o_moisture     = r_moisture;
    assign o_light        = r_light;
    assign o_m_dry        = r_m_dry;
    assign o_m_very_dry   = r_m_very_dry;
    assign o_l_dark       = r_l_dark;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_sensor_adc_sampler.sv
// Bench for sensor_adc_sampler: a CLK_DIV=2 instance driven by an MCP3002
// slave model with a table of readings/thresholds, plus a CLK_DIV=1,
// SAMPLE_PERIOD=500 instance for free-running period timing.

module tb_sensor_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: CLK_DIV=2, period long enough never to expire during the run.
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] th1 = '0, th2 = '0, lth = '0;
    logic       miso = 1'b0;
    logic       sclk, cs_n, mosi;
    logic [9:0] moisture, light;
    logic       m_dry, m_very_dry, l_dark, valid, busy;

    sensor_adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(50000)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_m_thresh_1(th1), .i_m_thresh_2(th2), .i_l_thresh(lth),
        .i_adc_miso(miso),
        .o_adc_sclk(sclk), .o_adc_cs_n(cs_n), .o_adc_mosi(mosi),
        .o_moisture(moisture), .o_light(light),
        .o_m_dry(m_dry), .o_m_very_dry(m_very_dry), .o_l_dark(l_dark),
        .o_sample_valid(valid), .o_busy(busy)
    );

    // Instance B: periodic sampling, ADC data line held high.
    logic       rst_n_b = 1'b1;
    logic       start_b = 1'b0;
    logic       miso_b = 1'b1;
    logic [9:0] th_b = 10'h200;
    logic       sclk_b, cs_n_b, mosi_b;
    logic [9:0] moisture_b, light_b;
    logic       m_dry_b, m_very_dry_b, l_dark_b, valid_b, busy_b;

    sensor_adc_sampler #(.CLK_DIV(1), .SAMPLE_PERIOD(500)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_start(start_b),
        .i_m_thresh_1(th_b), .i_m_thresh_2(th_b), .i_l_thresh(th_b),
        .i_adc_miso(miso_b),
        .o_adc_sclk(sclk_b), .o_adc_cs_n(cs_n_b), .o_adc_mosi(mosi_b),
        .o_moisture(moisture_b), .o_light(light_b),
        .o_m_dry(m_dry_b), .o_m_very_dry(m_very_dry_b), .o_l_dark(l_dark_b),
        .o_sample_valid(valid_b), .o_busy(busy_b)
    );

    // MCP3002 slave model: channel taken from command edge 3, data driven after
    // falling SCLK so it is stable at the next rising edge.
    logic [9:0] d0 = '0, d1 = '0;
    int         edge_n = 0;
    logic       ch_cap = 1'b0;
    logic [3:0] cur_cmd = '0;
    logic [3:0] cmd_log[$];

    always @(posedge sclk or negedge cs_n) begin
        if (sclk) begin
            edge_n = edge_n + 1;
            if (edge_n <= 4) cur_cmd = {cur_cmd[2:0], mosi};
            if (edge_n == 3) ch_cap = mosi;
            if (edge_n == 4) cmd_log.push_back(cur_cmd);
        end else begin
            edge_n = 0;
        end
    end

    always @(negedge sclk) begin
        int e;
        e = edge_n + 1;
        if (e >= 6 && e <= 15) miso = ch_cap ? d1[15-e] : d0[15-e];
        else miso = 1'b0;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs_n"}, int'(cs_n), 1);
        check({tag, "_sclk"}, int'(sclk), 0);
        check({tag, "_mosi"}, int'(mosi), 0);
        check({tag, "_moisture"}, int'(moisture), 0);
        check({tag, "_light"}, int'(light), 0);
        check({tag, "_flags"}, int'({m_dry, m_very_dry, l_dark}), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Pulses start, then watches 300 cycles. Optional second start at cycle
    // offset busy_start_at (0 = none).
    task automatic run_conv(input int busy_start_at, output int lat, output int npulse,
                            output int busy_bad);
        int c0;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        lat = -1;
        npulse = 0;
        busy_bad = 0;
        for (int i = 1; i <= 300; i++) begin
            start = (i == busy_start_at);
            if (valid) begin
                npulse++;
                if (lat < 0) lat = cyc - c0;
            end
            if (lat < 0 && !busy) busy_bad++;
            if (lat >= 0 && (cyc - c0) > lat && busy) busy_bad++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_conv(input string tag, input int base, input int lat,
                              input int npulse, input int busy_bad);
        int nfr;
        nfr = cmd_log.size() - base;
        check({tag, "_latency"}, lat, 141);
        check({tag, "_pulses"}, npulse, 1);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_frames"}, nfr, 2);
        check({tag, "_mosi_f0"}, (nfr >= 1) ? int'(cmd_log[base]) : -1, 13);
        check({tag, "_mosi_f1"}, (nfr >= 2) ? int'(cmd_log[base+1]) : -1, 15);
    endtask

    typedef struct {
        logic [9:0] d0, d1, t1, t2, lt;
        logic [9:0] em, el;
        logic       edry, evdry, edark;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, np, bb, base, found, nv, ncs, c_rel;
        int vt[3];
        string tag;

        // {ch0, ch1, thresh_1, thresh_2, l_thresh, moisture, light, dry, very_dry, dark}
        vecs[0] = '{10'h155, 10'h2AA, 10'h200, 10'h100, 10'h100, 10'h155, 10'h2AA, 1, 0, 0};
        vecs[1] = '{10'h100, 10'h010, 10'h100, 10'h0FF, 10'h011, 10'h100, 10'h010, 0, 0, 1};
        vecs[2] = '{10'h100, 10'h010, 10'h101, 10'h0FF, 10'h010, 10'h100, 10'h010, 1, 0, 0};
        vecs[3] = '{10'h000, 10'h3FF, 10'h001, 10'h001, 10'h3FF, 10'h000, 10'h3FF, 1, 1, 0};
        vecs[4] = '{10'h050, 10'h3FE, 10'h040, 10'h060, 10'h3FF, 10'h050, 10'h3FE, 0, 1, 1};
        vecs[5] = '{10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h000, 0, 0, 0};

        #12;
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        #1;
        check_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("v%0d", i);
            d0 = vecs[i].d0;
            d1 = vecs[i].d1;
            th1 = vecs[i].t1;
            th2 = vecs[i].t2;
            lth = vecs[i].lt;
            base = cmd_log.size();
            run_conv(0, lat, np, bb);
            check_conv(tag, base, lat, np, bb);
            check({tag, "_moisture"}, int'(moisture), int'(vecs[i].em));
            check({tag, "_light"}, int'(light), int'(vecs[i].el));
            check({tag, "_m_dry"}, int'(m_dry), int'(vecs[i].edry));
            check({tag, "_m_very_dry"}, int'(m_very_dry), int'(vecs[i].evdry));
            check({tag, "_l_dark"}, int'(l_dark), int'(vecs[i].edark));
        end

        // Threshold change without a conversion must not move the flags.
        lth = 10'h3FF;
        th1 = 10'h3FF;
        repeat (20) @(negedge clk);
        check("thr_hold_l_dark", int'(l_dark), 0);
        check("thr_hold_m_dry", int'(m_dry), 0);
        check("thr_hold_moisture", int'(moisture), 10'h3FF);

        // Start while busy (during CH1 shift) is dropped.
        d0 = 10'h155;
        d1 = 10'h2AA;
        th1 = 10'h200;
        th2 = 10'h100;
        base = cmd_log.size();
        run_conv(100, lat, np, bb);
        check_conv("busy_start", base, lat, np, bb);
        check("busy_start_moisture", int'(moisture), 10'h155);
        check("busy_start_light", int'(light), 10'h2AA);
        check("busy_start_flags", int'({m_dry, m_very_dry, l_dark}), 3'b101);

        // Reset during CH0 rising edge 10.
        d0 = 10'h0AA;
        d1 = 10'h055;
        base = cmd_log.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (sclk && edge_n == 10 && (cmd_log.size() - base) == 1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_edge10_reached", found, 1);
        check("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        ncs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid) nv++;
            if (!cs_n) ncs++;
        end
        check("midrst_no_valid", nv, 0);
        check("midrst_cs_idle", ncs, 0);
        check("midrst_moisture", int'(moisture), 0);
        check("midrst_light", int'(light), 0);

        base = cmd_log.size();
        run_conv(0, lat, np, bb);
        check_conv("post_rst", base, lat, np, bb);
        check("post_rst_moisture", int'(moisture), 10'h0AA);
        check("post_rst_light", int'(light), 10'h055);

        // Periodic sampling on instance B.
        @(negedge clk);
        rst_n_b = 1'b1;
        c_rel = cyc;
        nv = 0;
        for (int i = 0; i < 2000 && nv < 3; i++) begin
            @(negedge clk);
            if (valid_b) begin
                vt[nv] = cyc;
                nv++;
            end
        end
        check("per_pulses", nv, 3);
        check("per_first", (nv >= 1) ? vt[0] - c_rel : -1, 571);
        check("per_gap1", (nv >= 2) ? vt[1] - vt[0] : -1, 572);
        check("per_gap2", (nv >= 3) ? vt[2] - vt[1] : -1, 572);
        check("per_moisture", int'(moisture_b), 10'h3FF);
        check("per_light", int'(light_b), 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_adc_sampler.md
# sensor_adc_sampler

Upstream sensor front end for the irrigation controller FSM. It periodically reads a 2-channel, 10-bit SPI ADC (MCP3002 command format): channel 0 is soil moisture and channel 1 is ambient light. It holds the latest pair of readings, and compares them against programmable thresholds. The resulting moisture and light flags drive the FSM's sense inputs directly.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- SAMPLE_PERIOD, 1000000: clk cycles between automatic conversions; must exceed 70*CLK_DIV+2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request for an immediate conversion.
- m_thresh_1  input  10  moisture threshold for "dry" (the higher threshold).
- m_thresh_2  input  10  moisture threshold for "very dry" (the lower threshold).
- l_thresh  input  10  light threshold for "dark".
- adc_miso  input  1  ADC serial data out.
- adc_sclk  output  1  SPI clock, mode 0 (idles low).
- adc_cs_n  output  1  ADC chip select, active low.
- adc_mosi  output  1  ADC serial command in.
- moisture  output  10  last moisture code.
- light  output  10  last light code.
- m_dry  output  1  moisture < m_thresh_1.
- m_very_dry  output  1  moisture < m_thresh_2.
- l_dark  output  1  light < l_thresh.
- sample_valid  output  1  one-cycle pulse when moisture, light and all three flags update.
- busy  output  1  high from trigger acceptance until sample_valid.

## Operation
- **Reset values (asynchronous, immediate).**
  - adc_cs_n=1, adc_sclk=0, adc_mosi=0.
  - moisture=0, light=0.
  - m_dry=0, m_very_dry=0, l_dark=0.
  - sample_valid=0, busy=0.
  - Period counter=0; FSM in IDLE.
- **Trigger sources.**
  - A trigger is either start=1 in IDLE, or the period counter reaching SAMPLE_PERIOD-1 in IDLE.
  - On acceptance the period counter reloads to 0.
  - start while busy is dropped, not queued.
  - If start and a period expiry occur in the same cycle, one conversion runs.
- **State sequence per conversion.** IDLE -> {CS_SETUP -> SHIFT -> CS_HOLD -> GAP} for channel 0, the same sequence for channel 1, then UPDATE -> IDLE.
- **CS_SETUP:** adc_cs_n=0 and adc_sclk=0 for CLK_DIV cycles; adc_mosi presents command bit 1.
- **SHIFT:** 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - MOSI command, MSB first, for rising edges 1..4: 1 (start), 1 (single-ended), CH (0 or 1), 1 (MSBF).
  - adc_mosi changes only while SCLK is low; it is 0 after edge 4.
  - adc_miso is sampled on the clk edge on which adc_sclk rises.
  - Edge 5 is the null bit and is ignored; edges 6..15 shift in D9..D0; edge 16 is ignored.
- **CS_HOLD:** SCLK low, CS low, for CLK_DIV cycles.
- **GAP:** adc_cs_n=1 for CLK_DIV cycles.
- **UPDATE (1 cycle).**
  - moisture and light load from their channel shadow registers simultaneously.
  - Flags are registered from the newly loaded values, so all update in the same cycle.
  - sample_valid=1 for exactly that cycle.
  - busy is cleared on the following edge.
- **Comparisons.** Unsigned 10-bit, strict less-than. A reading equal to a threshold does not set the flag.
- **Threshold changes.** Changing a threshold takes effect at the next UPDATE only; flags are not recomputed continuously.
- **Flag consistency.** m_very_dry=1 with m_dry=0 is legal if m_thresh_2 > m_thresh_1. The block does not enforce threshold ordering.
- **Period counter.** Runs only in IDLE and saturates at its terminal value.
- **Reset mid-conversion.**
  - Returns to the reset state immediately, with no partial SCLK pulse and no output update.
  - After release, the next conversion starts from the beginning of the channel 0 frame.

## Timing
- Each frame takes 35*CLK_DIV cycles: CLK_DIV setup + 32*CLK_DIV shift + CLK_DIV hold + CLK_DIV gap.
- sample_valid asserts exactly 70*CLK_DIV+1 cycles after the trigger cycle.
- busy rises on the edge following the trigger cycle and falls one cycle after sample_valid.
- With no start activity, conversions begin every SAMPLE_PERIOD + 70*CLK_DIV + 2 cycles.
- Outputs hold their values between UPDATE cycles.

## Test plan
- **Reset.** Assert rst_n=0 mid-stream.
  - All outputs must take their reset values within the same cycle.
  - The first trigger after reset must run a full two-frame conversion.
- **Single conversion.** CLK_DIV=2; an SPI slave model returns 0x155 on CH0 and 0x2AA on CH1; pulse start.
  - moisture=0x155 and light=0x2AA.
  - sample_valid is a single pulse exactly 141 cycles after start.
  - MOSI bits are 1,1,0,1 on frame 0 and 1,1,1,1 on frame 1.
- **Threshold boundaries.** moisture=0x100 with m_thresh_1=0x100 and m_thresh_2=0x0FF -> m_dry=0, m_very_dry=0.
  - With m_thresh_1=0x101 -> m_dry=1, m_very_dry=0.
  - light=0x010 with l_thresh=0x011 -> l_dark=1.
- **Start while busy.** Pulse start during the CH1 SHIFT phase.
  - No additional frame is run; exactly one sample_valid is produced.
  - busy stays high continuously until that pulse.
- **Reset mid-frame.** Assert rst_n=0 during CH0 edge 10.
  - moisture and light keep their reset values of 0; no sample_valid is produced.
  - adc_cs_n=1 immediately.
- **Periodic sampling.** SAMPLE_PERIOD=500, CLK_DIV=1, no start.
  - Consecutive sample_valid pulses are exactly 572 cycles apart.
